// File: rtl/a51_pkg.sv
// Shared types and constants for the A5/1 stream engine.
// Register geometry, tap masks and the engine state encoding.
package a51_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_FRAME,
    MIX,
    READY,
    GEN,
    HOLD
  } state_e;

  typedef enum logic {
    STEP_REG,
    STEP_MAJ
  } step_e;

  localparam int KEY_W = 64;

  localparam int R1_W = 19;
  localparam int R2_W = 22;
  localparam int R3_W = 23;

  localparam logic [R1_W-1:0] R1_TAPS = 19'h07_2000;
  localparam logic [R2_W-1:0] R2_TAPS = 22'h30_0000;
  localparam logic [R3_W-1:0] R3_TAPS = 23'h70_0080;

  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a51_lfsr_core.sv
// Combinational next-state of the three A5/1 LFSRs.
// Regular mode steps all and injects a bit; majority mode stops one.
module a51_lfsr_core
  import a51_pkg::*;
(
  input  logic [R1_W-1:0] r1,
  input  logic [R2_W-1:0] r2,
  input  logic [R3_W-1:0] r3,
  input  step_e           mode,
  input  logic            inject,
  output logic [R1_W-1:0] r1_next,
  output logic [R2_W-1:0] r2_next,
  output logic [R3_W-1:0] r3_next,
  output logic            ks
);

  logic maj;
  logic reg_mode;
  logic inj;
  logic s1, s2, s3;
  logic [R1_W-1:0] sh1;
  logic [R2_W-1:0] sh2;
  logic [R3_W-1:0] sh3;

  always_comb begin
    reg_mode = (mode == STEP_REG);
    inj = inject & reg_mode;
    maj = maj3(r1[R1_CLK], r2[R2_CLK], r3[R3_CLK]);

    s1 = reg_mode | (r1[R1_CLK] == maj);
    s2 = reg_mode | (r2[R2_CLK] == maj);
    s3 = reg_mode | (r3[R3_CLK] == maj);

    sh1 = {r1[R1_W-2:0], (^(r1 & R1_TAPS)) ^ inj};
    sh2 = {r2[R2_W-2:0], (^(r2 & R2_TAPS)) ^ inj};
    sh3 = {r3[R3_W-2:0], (^(r3 & R3_TAPS)) ^ inj};

    r1_next = s1 ? sh1 : r1;
    r2_next = s2 ? sh2 : r2;
    r3_next = s3 ? sh3 : r3;

    // keystream comes from the post-step register contents
    ks = r1_next[R1_W-1]
       ^ r2_next[R2_W-1]
       ^ r3_next[R3_W-1];
  end

endmodule

// File: rtl/a51_stream_engine.sv
// A5/1 keystream engine: key/frame setup, mix phase, then
// MSB-first word encryption over valid/ready streams.
module a51_stream_engine
  import a51_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FRAME_W    = 22,
  parameter int MIX_CYCLES = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KEY_W-1:0]   key,
  input  logic [FRAME_W-1:0] frame,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data
);

  localparam int M1 = (KEY_W > FRAME_W) ? KEY_W : FRAME_W;
  localparam int M2 = (M1 > MIX_CYCLES) ? M1 : MIX_CYCLES;
  localparam int MAX_N = (M2 > DATA_W) ? M2 : DATA_W;
  localparam int CNT_W = $clog2(MAX_N + 1);

  localparam logic [CNT_W-1:0] KEY_END = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] FRM_END = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] MIX_END = CNT_W'(MIX_CYCLES - 1);
  localparam logic [CNT_W-1:0] GEN_END = CNT_W'(DATA_W - 1);

  state_e state;
  state_e state_nx;
  logic [CNT_W-1:0] cnt;

  logic [KEY_W-1:0]   key_q;
  logic [FRAME_W-1:0] frame_q;
  logic [KEY_W-1:0]   key_sh;
  logic [FRAME_W-1:0] frame_sh;

  logic [R1_W-1:0] r1, r1_nx;
  logic [R2_W-1:0] r2, r2_nx;
  logic [R3_W-1:0] r3, r3_nx;

  step_e mode;
  logic  inject;
  logic  step_en;
  logic  ks;

  logic [DATA_W-1:0] dat_q;
  logic [DATA_W-1:0] dat_mix;
  logic [CNT_W-1:0]  bit_sh;

  a51_lfsr_core u_core (
    .r1      (r1),
    .r2      (r2),
    .r3      (r3),
    .mode    (mode),
    .inject  (inject),
    .r1_next (r1_nx),
    .r2_next (r2_nx),
    .r3_next (r3_nx),
    .ks      (ks)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state logic; start overrides everything but reset
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = IDLE;
      LOAD_KEY:
        if (cnt == KEY_END) state_nx = LOAD_FRAME;
      LOAD_FRAME:
        if (cnt == FRM_END)
          state_nx = (MIX_CYCLES == 0) ? READY : MIX;
      MIX:
        if (cnt == MIX_END) state_nx = READY;
      READY:
        if (in_valid) state_nx = GEN;
      GEN:
        if (cnt == GEN_END) state_nx = HOLD;
      HOLD:
        if (out_ready) state_nx = READY;
      default: state_nx = IDLE;
    endcase
    if (start) state_nx = LOAD_KEY;
  end

  // output decode
  always_comb begin
    busy      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      LOAD_KEY, LOAD_FRAME, MIX: busy = 1'b1;
      READY:   in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (start || state_nx != state) begin
      cnt <= '0;
    end else if (state == LOAD_KEY || state == LOAD_FRAME
              || state == MIX || state == GEN) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    key_sh   = key_q >> cnt;
    frame_sh = frame_q >> cnt;
    mode     = STEP_MAJ;
    inject   = 1'b0;
    step_en  = 1'b0;
    unique case (state)
      LOAD_KEY: begin
        mode    = STEP_REG;
        inject  = key_sh[0];
        step_en = 1'b1;
      end
      LOAD_FRAME: begin
        mode    = STEP_REG;
        inject  = frame_sh[0];
        step_en = 1'b1;
      end
      MIX, GEN: step_en = 1'b1;
      default:  step_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r1      <= '0;
      r2      <= '0;
      r3      <= '0;
      key_q   <= '0;
      frame_q <= '0;
    end else if (start) begin
      r1      <= '0;
      r2      <= '0;
      r3      <= '0;
      key_q   <= key;
      frame_q <= frame;
    end else if (step_en) begin
      r1 <= r1_nx;
      r2 <= r2_nx;
      r3 <= r3_nx;
    end
  end

  // bit k of the keystream lands on data bit DATA_W-1-k
  always_comb begin
    bit_sh  = GEN_END - cnt;
    dat_mix = dat_q ^ (DATA_W'(ks) << bit_sh);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dat_q    <= '0;
      out_data <= '0;
    end else if (state == READY && in_valid) begin
      dat_q <= in_data;
    end else if (state == GEN) begin
      dat_q <= dat_mix;
      if (cnt == GEN_END) out_data <= dat_mix;
    end
  end

endmodule

// File: tb/tb_a51_stream_engine.sv
// Randomized self-checking bench for a51_stream_engine
// against a bit-level A5/1 reference model.
module tb_a51_stream_engine;

  localparam logic [63:0] REF_KEY = 64'hEFCD_AB89_6745_2312;
  localparam logic [21:0] REF_FRM = 22'h134;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] key = '0;
  logic [21:0] frame = '0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;

  int total = 0;
  int bad = 0;

  bit [18:0] m1;
  bit [21:0] m2;
  bit [22:0] m3;
  bit        ksq[$];

  always #5 clk = ~clk;

  a51_stream_engine #(
    .DATA_W     (8),
    .FRAME_W    (22),
    .MIX_CYCLES (100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key       (key),
    .frame     (frame),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: one clock of the three registers
  task automatic m_clock(input bit all3, input bit inj);
    int votes;
    bit maj;
    votes = int'(m1[8]) + int'(m2[10]) + int'(m3[10]);
    maj = (votes >= 2);
    if (all3 || m1[8] == maj)
      m1 = {m1[17:0], ^(m1 & 19'h72000)} ^ 19'(inj);
    if (all3 || m2[10] == maj)
      m2 = {m2[20:0], ^(m2 & 22'h300000)} ^ 22'(inj);
    if (all3 || m3[10] == maj)
      m3 = {m3[21:0], ^(m3 & 23'h700080)} ^ 23'(inj);
  endtask

  task automatic model_setup(
    input bit [63:0] k,
    input bit [21:0] f,
    input int        nbits
  );
    m1 = '0;
    m2 = '0;
    m3 = '0;
    for (int i = 0; i < 64; i++) m_clock(1'b1, k[i]);
    for (int j = 0; j < 22; j++) m_clock(1'b1, f[j]);
    for (int i = 0; i < 100; i++) m_clock(1'b0, 1'b0);
    ksq.delete();
    for (int i = 0; i < nbits; i++) begin
      m_clock(1'b0, 1'b0);
      ksq.push_back(m1[18] ^ m2[21] ^ m3[22]);
    end
  endtask

  function automatic logic [7:0] exp_word(input logic [7:0] pt);
    logic [7:0] w;
    w = pt;
    for (int b = 7; b >= 0; b--) w[b] = w[b] ^ ksq.pop_front();
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(
    input logic [63:0] k,
    input logic [21:0] f
  );
    key = k;
    frame = f;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(
    input  logic [7:0] pt,
    input  int         stall,
    output logic [7:0] ct
  );
    int n;
    n = 0;
    while (!in_ready && n < 400) begin
      tick();
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data = pt;
    tick();
    in_valid = 1'b0;
    chk("in_ready_drop", in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("gen_latency", n, 8);
    ct = out_data;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, ct);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ov_drop", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ct;
    logic [7:0] pt;
    logic [63:0] rk;
    logic [21:0] rf;
    int errs;
    int n;
    logic [7:0] ref_ct[4];
    ref_ct[0] = 8'h53;
    ref_ct[1] = 8'h4E;
    ref_ct[2] = 8'hAA;
    ref_ct[3] = 8'h58;

    // reset, with start held to show reset wins
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // setup latency and reference vector with backpressure
    model_setup(REF_KEY, REF_FRM, 32);
    pulse_start(REF_KEY, REF_FRM);
    errs = 0;
    for (int c = 1; c <= 186; c++) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) errs++;
      if (c < 186) tick();
    end
    chk("busy_window", errs, 0);
    tick();
    chk("ready_at_187", in_ready, 1);
    chk("busy_off_187", busy, 0);
    for (int w = 0; w < 4; w++) begin
      send_word(8'h00, (w == 0) ? 10 : 0, ct);
      chk("ref_const", ct, ref_ct[w]);
      chk("ref_model", ct, exp_word(8'h00));
    end

    // plaintext xor, then decrypt with a fresh session
    pulse_start(REF_KEY, REF_FRM);
    send_word(8'hFF, 0, ct);
    chk("enc_ff", ct, 8'hAC);
    pulse_start(REF_KEY, REF_FRM);
    send_word(8'hAC, 0, ct);
    chk("dec_ac", ct, 8'hFF);

    // restart three cycles into GEN
    n = 0;
    while (!in_ready && n < 400) begin
      tick();
      n++;
    end
    in_valid = 1'b1;
    in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    pulse_start(REF_KEY, REF_FRM);
    errs = 0;
    n = 0;
    while (!in_ready && n < 400) begin
      if (out_valid) errs++;
      tick();
      n++;
    end
    chk("restart_no_ov", errs, 0);
    chk("restart_setup", n, 186);
    model_setup(REF_KEY, REF_FRM, 8);
    send_word(8'h00, 0, ct);
    chk("restart_word", ct, 8'h53);
    chk("restart_model", ct, exp_word(8'h00));

    // reset in the middle of MIX
    pulse_start(REF_KEY, REF_FRM);
    for (int i = 0; i < 120; i++) tick();
    chk("mix_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mixrst_busy", busy, 0);
    chk("mixrst_in_ready", in_ready, 0);
    chk("mixrst_out_valid", out_valid, 0);
    chk("mixrst_out_data", out_data, 0);
    in_valid = 1'b1;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (in_ready !== 1'b0 || out_valid !== 1'b0
          || busy !== 1'b0) errs++;
    end
    in_valid = 1'b0;
    chk("idle_ignores_valid", errs, 0);

    // randomized sessions against the model
    for (int s = 0; s < 4; s++) begin
      rk = {$urandom(), $urandom()};
      rf = 22'($urandom());
      model_setup(rk, rf, 8 * 6);
      pulse_start(rk, rf);
      for (int w = 0; w < 6; w++) begin
        pt = 8'($urandom());
        send_word(pt, int'($urandom_range(0, 3)), ct);
        chk("rand_word", ct, exp_word(pt));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
